// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and RAM geometry for the data-memory LSU
package lsu_pkg;

  localparam int RAM_AW = 10;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_STROBE,
    RD_CAPTURE,
    WR_SETUP,
    WR_STROBE,
    WR_DONE
  } state_e;

  // Misalignment/illegal-size check for an incoming request.
  function automatic logic req_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  req_misaligned = 1'b0;
      SIZE_H:  req_misaligned = addr_lo[0];
      SIZE_W:  req_misaligned = (addr_lo != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - load lane extraction/extension and store lane merge
// Ports:
//   size        access size (SIZE_X behaves as a word)
//   is_unsigned zero-extend sub-word loads
//   addr_lo     byte offset within the word
//   word_in     word read from RAM
//   store_data  right-aligned store data
//   load_data   extracted, extended load result
//   merged_word word_in with the store lane(s) replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane   = word_in[{addr_lo, 3'b000} +: 8];
    half_lane   = word_in[{addr_lo[1], 4'b0000} +: 16];
    load_data   = word_in;
    merged_word = store_data;
    case (size)
      SIZE_B: begin
        load_data   = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merged_word = word_in;
        merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      end
      SIZE_H: begin
        // addr_lo[0] is ignored: the half lane is selected by addr_lo[1] only.
        load_data   = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merged_word = word_in;
        merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: begin
        load_data   = word_in;
        merged_word = store_data;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - load/store unit driving the 1024x32 data RAM with setup/strobe/hold sequencing
// Optional feature macro: LSU_MISALIGN_TRAP_EN (report misaligned/illegal requests via rsp_err).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned   store flag, access size, zero-extend loads
//   req_addr, req_wdata              byte address, right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err    completion pulse, load data, error flag
//   ram_read_enable/ram_write_enable registered edge strobes
//   ram_read_address/ram_write_address word address captured at accept
//   ram_data_in, ram_data_out        RAM write/read data
module data_mem_lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [11:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [RAM_AW-1:0] ram_read_address,
  output logic [RAM_AW-1:0] ram_write_address,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out
);

  state_e      state_q, state_d;
  logic [11:0] addr_q;
  size_e       size_q;
  logic        we_q, uns_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic        req_is_word;
  logic        ready_d, rsp_valid_d, rsp_err_d, rd_en_d, wr_en_d;
  logic [31:0] rsp_rdata_d, ram_data_in_d;
  logic [31:0] load_data, merged_word;

  assign ram_read_address  = addr_q[11:2];
  assign ram_write_address = addr_q[11:2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = req_misaligned(size_e'(req_size), req_addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  // Size 11 only reaches the datapath when trapping is disabled; it is a word access then.
  assign req_is_word = (req_size == SIZE_W) || (req_size == SIZE_X);

  lsu_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .word_in     (ram_data_out),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rd_en_d       = 1'b0;
    wr_en_d       = 1'b0;
    ram_data_in_d = ram_data_in;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            // Errors complete from IDLE without touching the RAM.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (req_we && req_is_word) begin
            ram_data_in_d = req_wdata;
            state_d       = WR_SETUP;
          end else begin
            state_d = RD_SETUP;
          end
        end
      end
      RD_SETUP: begin
        rd_en_d = 1'b1;
        state_d = RD_STROBE;
      end
      RD_STROBE: state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        if (we_q) begin
          // Sub-word store: write back the captured word with the new lane(s).
          ram_data_in_d = merged_word;
          state_d       = WR_SETUP;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          state_d     = IDLE;
        end
      end
      WR_SETUP: begin
        wr_en_d = 1'b1;
        state_d = WR_STROBE;
      end
      WR_STROBE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0;
        state_d     = WR_DONE;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= 12'h0;
      size_q           <= SIZE_B;
      we_q             <= 1'b0;
      uns_q            <= 1'b0;
      wdata_q          <= 32'h0;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_rdata        <= 32'h0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_data_in      <= 32'h0;
    end else begin
      state_q          <= state_d;
      req_ready        <= ready_d;
      rsp_valid        <= rsp_valid_d;
      rsp_err          <= rsp_err_d;
      rsp_rdata        <= rsp_rdata_d;
      ram_read_enable  <= rd_en_d;
      ram_write_enable <= wr_en_d;
      ram_data_in      <= ram_data_in_d;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= size_e'(req_size);
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed self-checking bench for data_mem_lsu with a strobe-driven RAM model
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [11:0] req_addr = 12'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_read_enable, ram_write_enable;
  logic [9:0]  ram_read_address, ram_write_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  logic [31:0] mem [0:1023];
  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int viol = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  always #5 clk = ~clk;

  data_mem_lsu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .ram_read_enable   (ram_read_enable),
    .ram_write_enable  (ram_write_enable),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_data_in       (ram_data_in),
    .ram_data_out      (ram_data_out)
  );

  // RAM model: write process owns mem (including preload).
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h22222222;
    mem[1] = 32'hDEADBEEF;
    mem[2] = 32'hA5A5A5A5;
    mem[3] = 32'h5A5A5A5A;
    forever begin
      @(posedge ram_write_enable);
      mem[ram_write_address] = ram_data_in;
      wr_cnt++;
    end
  end

  initial begin
    ram_data_out = 32'h0;
    forever begin
      @(posedge ram_read_enable);
      ram_data_out = mem[ram_read_address];
      rd_cnt++;
    end
  end

  always @(negedge clk) begin
    if ((ram_read_enable && prev_rd) || (ram_write_enable && prev_wr)) viol++;
    prev_rd = ram_read_enable;
    prev_wr = ram_write_enable;
  end

  // Issues one request (called #1 after a clk edge) and waits for its response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nrd, output int nwr);
    int rd0, wr0, guard;
    logic done;
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; done = 1'b0; rdata = 32'hx; err = 1'bx;
    while (!done && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (rsp_valid) begin
        done = 1'b1; rdata = rsp_rdata; err = rsp_err;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", lat);
    end
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nrd, nwr;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, ram_read_enable, ram_write_enable} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_err, ram_read_enable, ram_write_enable});
    end
    checks++;
    if ({rsp_rdata, ram_data_in, ram_read_address, ram_write_address} !== 84'h0) begin
      errors++; $display("FAIL reset_data: rdata=%h din=%h ra=%h wa=%h want 0", rsp_rdata, ram_data_in, ram_read_address, ram_write_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    do_req(1'b1, 2'b10, 1'b0, 12'h004, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++;
    if ({nrd, nwr} !== {32'd0, 32'd1}) begin errors++; $display("FAIL sw_strobes: rd=%0d wr=%0d want 0/1", nrd, nwr); end
    checks++;
    if ({rd, er} !== 33'h0) begin errors++; $display("FAIL sw_rsp: rdata=%h err=%b want 0/0", rd, er); end
    checks++;
    if (mem[1] !== 32'h0) begin errors++; $display("FAIL sw_mem: got %h want 00000000", mem[1]); end
    do_req(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
    checks++;
    if ({nrd, nwr} !== {32'd1, 32'd0}) begin errors++; $display("FAIL lw_strobes: rd=%0d wr=%0d want 1/0", nrd, nwr); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL lw_data: got %h want 00000000", rd); end
  endtask

  task automatic test_preload_lb();
    do_req(1'b0, 2'b00, 1'b0, 12'h000, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'h00000022) begin errors++; $display("FAIL lb0_data: got %h want 00000022", rd); end
  endtask

  task automatic test_byte();
    do_req(1'b1, 2'b00, 1'b0, 12'h005, 32'h12345680, rd, er, lat, nrd, nwr);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL sb_latency: got %0d want 5", lat); end
    checks++;
    if ({nrd, nwr} !== {32'd1, 32'd1}) begin errors++; $display("FAIL sb_strobes: rd=%0d wr=%0d want 1/1", nrd, nwr); end
    do_req(1'b0, 2'b00, 1'b0, 12'h005, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb5_data: got %h want ffffff80", rd); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL rdata_hold: got %h want ffffff80", rsp_rdata); end
    do_req(1'b0, 2'b00, 1'b1, 12'h005, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu5_data: got %h want 00000080", rd); end
    do_req(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'h00008000) begin errors++; $display("FAIL lw4_after_sb: got %h want 00008000", rd); end
  endtask

  task automatic test_half();
    do_req(1'b1, 2'b01, 1'b0, 12'h006, 32'hAAAABEEF, rd, er, lat, nrd, nwr);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL sh_latency: got %0d want 5", lat); end
    do_req(1'b0, 2'b01, 1'b0, 12'h006, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh6_data: got %h want ffffbeef", rd); end
    do_req(1'b0, 2'b01, 1'b1, 12'h006, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu6_data: got %h want 0000beef", rd); end
    do_req(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'hBEEF8000) begin errors++; $display("FAIL lw4_after_sh: got %h want beef8000", rd); end
  endtask

  task automatic test_misalign();
    do_req(1'b0, 2'b10, 1'b0, 12'h002, 32'h0, rd, er, lat, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw2_err: err=%b rdata=%h want 1/0", er, rd); end
    checks++;
    if ({lat, nrd, nwr} !== {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL lw2_timing: lat=%0d rd=%0d wr=%0d want 1/0/0", lat, nrd, nwr); end
`else
    checks++;
    if ({er, rd} !== {1'b0, 32'h22222222}) begin errors++; $display("FAIL lw2_noerr: err=%b rdata=%h want 0/22222222", er, rd); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lw2_latency: got %0d want 3", lat); end
`endif
    do_req(1'b1, 2'b10, 1'b0, 12'h009, 32'h00000099, rd, er, lat, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if ({er, nwr, mem[2]} !== {1'b1, 32'd0, 32'hA5A5A5A5}) begin errors++; $display("FAIL sw9_err: err=%b wr=%0d mem=%h want 1/0/a5a5a5a5", er, nwr, mem[2]); end
`else
    checks++;
    if ({er, lat, mem[2]} !== {1'b0, 32'd2, 32'h00000099}) begin errors++; $display("FAIL sw9_noerr: err=%b lat=%0d mem=%h want 0/2/00000099", er, lat, mem[2]); end
`endif
    do_req(1'b0, 2'b01, 1'b0, 12'h001, 32'h0, rd, er, lat, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if ({er, rd, nrd} !== {1'b1, 32'h0, 32'd0}) begin errors++; $display("FAIL lh1_err: err=%b rdata=%h rd=%0d want 1/0/0", er, rd, nrd); end
`else
    checks++;
    if ({er, rd} !== {1'b0, 32'h00002222}) begin errors++; $display("FAIL lh1_noerr: err=%b rdata=%h want 0/00002222", er, rd); end
`endif
    do_req(1'b0, 2'b11, 1'b0, 12'h000, 32'h0, rd, er, lat, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if ({er, rd, lat} !== {1'b1, 32'h0, 32'd1}) begin errors++; $display("FAIL size3_err: err=%b rdata=%h lat=%0d want 1/0/1", er, rd, lat); end
`else
    checks++;
    if ({er, rd, lat} !== {1'b0, 32'h22222222, 32'd3}) begin errors++; $display("FAIL size3_word: err=%b rdata=%h lat=%0d want 0/22222222/3", er, rd, lat); end
`endif
  endtask

  task automatic test_boundary();
    do_req(1'b1, 2'b10, 1'b0, 12'hFFC, 32'h12345678, rd, er, lat, nrd, nwr);
    checks++;
    if (mem[1023] !== 32'h12345678) begin errors++; $display("FAIL top_word_mem: got %h want 12345678", mem[1023]); end
    do_req(1'b0, 2'b00, 1'b1, 12'hFFF, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'h00000012) begin errors++; $display("FAIL lbu_fff: got %h want 00000012", rd); end
    do_req(1'b0, 2'b01, 1'b0, 12'hFFE, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_ffe: got %h want 00001234", rd); end
  endtask

  task automatic test_reset_mid();
    int wr0, guard;
    logic seen;
    wr0 = wr_cnt; seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 12'h00C; req_wdata = 32'h00000055;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_read_enable, ram_write_enable, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL midrst_outputs: got %b want 000", {ram_read_enable, ram_write_enable, rsp_valid});
    end
    repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: rsp_valid seen=%b want 0", seen); end
    checks++;
    if ({wr_cnt - wr0, mem[3]} !== {32'd0, 32'h5A5A5A5A}) begin
      errors++; $display("FAIL midrst_mem: writes=%0d mem=%h want 0/5a5a5a5a", wr_cnt - wr0, mem[3]);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 12'h00C, 32'h0, rd, er, lat, nrd, nwr);
    checks++;
    if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL midrst_reload: got %h want 5a5a5a5a", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_preload_lb();
    test_byte();
    test_half();
    test_misalign();
    test_boundary();
    test_reset_mid();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL strobe_spacing: consecutive strobe cycles=%0d want 0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit that initiates all accesses to the 1024×32 data RAM on behalf of the RISC-V core. Accepts byte/half/word load and store requests on a valid/ready handshake. Generates the RAM's edge-triggered read and write strobes with address setup and hold. Performs sign/zero extension for loads and read-modify-write for sub-word stores. Sits between the execute/memory stage and the data RAM.

## Interface
- No parameters; the RAM geometry of 1024 words × 32 bits is fixed.
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend (LBU/LHU)
- req_addr  in  12  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; held until the next rsp_valid; 0 for stores
- rsp_err  out  1  misaligned or illegal request, valid with rsp_valid
- ram_read_enable  out  1  read strobe; RAM samples on its rising edge
- ram_write_enable  out  1  write strobe; RAM writes on its rising edge
- ram_read_address, ram_write_address  out  10 each  both equal req_addr[11:2] as registered at accept
- ram_data_in  out  32  write data to RAM
- ram_data_out  in  32  read data from RAM

## Operation
- FSM states: IDLE, RD_SETUP, RD_STROBE, RD_CAPTURE, WR_SETUP, WR_STROBE, WR_DONE.
- Accept: register addr, size, we, unsigned, wdata.
  - Load or sub-word store → RD_SETUP.
  - Word store → WR_SETUP, with ram_data_in = wdata.
- Read path:
  - RD_SETUP: addresses stable, strobes low.
  - RD_STROBE: ram_read_enable = 1.
  - RD_CAPTURE: strobe low; ram_data_out is sampled at the end of this cycle.
- After capture, a load goes to IDLE and pulses rsp_valid with the extracted data.
- After capture, a sub-word store merges the new lane(s) into the captured word, loads the result into ram_data_in, then proceeds WR_SETUP → WR_STROBE → WR_DONE.
- Write path:
  - WR_SETUP: data and address stable.
  - WR_STROBE: ram_write_enable = 1.
  - WR_DONE: strobe low, rsp_valid pulses, then IDLE.
- Lanes are little-endian; byte k = bits [8k+7:8k], with k = addr[1:0]. Half-word lane = addr[1].
- Load extension: sign-extend from bit 7/15 unless req_unsigned. Word loads ignore req_unsigned.
- Strobes are registered outputs and never high in two consecutive cycles.
- Each strobe is preceded by at least one cycle of stable address/data.

## Timing
- Reset values:
  - All outputs 0 except req_ready = 1; the FSM is in IDLE.
  - Reset mid-operation drops strobes immediately and abandons the access; no rsp_valid.
  - A write strobe that had already risen has committed.
- Latency from the accept edge to rsp_valid:
  - Load: 3 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 5 cycles.
  - Error request: 1 cycle, with no RAM strobe.
- req_ready is high in the rsp_valid cycle, so back-to-back requests lose no cycle beyond the latency.
- rsp_err conditions:
  - req_size = 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] ≠ 00.
- On an error, rsp_rdata = 0 and RAM contents are untouched.
- Address 0xFFC–0xFFF maps to word 1023; there is no wrap beyond the RAM.

## Configuration
- LSU_MISALIGN_TRAP_EN
  - Defined: misaligned and illegal requests complete with rsp_err = 1 as above.
  - Undefined:
    - rsp_err is tied 0.
    - Half ignores addr[0]; word ignores addr[1:0].
    - Size 11 is treated as word.
    - All requests access the RAM with the normal latency.

## Structure
- Package lsu_pkg: size encodings (SIZE_B, SIZE_H, SIZE_W), the FSM state enum, and RAM_AW = 10.
- Sub-module lsu_lane_align: combinational load extraction/extension and store lane merge, shared by the read and RMW paths.

## Test plan
- SW 0x00000000 @0x004, then LW @0x004 → rsp_rdata 0x00000000; latencies 2 then 3; exactly one write strobe then one read strobe.
- LB @0x000 after reset (RAM word 0 preloaded 0x22222222) → rsp_rdata 0x00000022.
- SB 0x80 @0x005, then LB @0x005 → 0xFFFFFF80, LBU → 0x00000080, LW @0x004 → 0x00008000; SB latency 5.
- SH 0xBEEF @0x006, then LH @0x006 → 0xFFFFBEEF, LW @0x004 → 0xBEEF8000.
- With the macro defined, LW @0x002 → rsp_err = 1 after 1 cycle, no strobes, memory unchanged. With the macro undefined, the same request → reads word 0, rsp_err = 0.
- Assert rst_n low during WR_SETUP of an SB → strobes low, no rsp_valid, target word unchanged; req_ready = 1 after release.
